// File: rtl/instr_fetch_master.sv
// Instruction-fetch initiator: sequential PC fetches over req/gnt, in-order
// response tagging, small instruction FIFO toward a valid/ready consumer,
// and redirect with flush of buffered and in-flight instructions.
module instr_fetch_master #(
  parameter logic [31:0] BOOT_ADDR       = 32'h0000_0080,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic [31:0] instr_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i,
  output logic        busy_o,
  output logic        err_o
);

  localparam int unsigned FA_W = $clog2(FIFO_DEPTH);
  localparam int unsigned FC_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OC_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned QA_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [31:0] NO_OP = 32'h0000_0013;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [31:0]     fetch_pc_q;
  logic [OC_W-1:0] out_q;
  logic [OC_W-1:0] discard_q;
  logic            err_q;

  logic [31:0]     pcq_mem [MAX_OUTSTANDING];
  logic [QA_W-1:0] pcq_wr_q, pcq_rd_q;

  logic [31:0]     fifo_pc_mem   [FIFO_DEPTH];
  logic [31:0]     fifo_data_mem [FIFO_DEPTH];
  logic [FA_W-1:0] fifo_wr_q, fifo_rd_q;
  logic [FC_W-1:0] fifo_cnt_q;

  logic issue, gnt_ok, gnt_bad, flush, push, drop, pop, fifo_empty;

  // Handshake decode; every operand is a registered value except the strobes
  always_comb begin
    fifo_empty = (fifo_cnt_q == '0);
    gnt_ok     = instr_gnt_i && (out_q != '0);
    gnt_bad    = instr_gnt_i && (out_q == '0);
    issue      = (state_q == S_RUN) && !redirect_i &&
                 (32'(out_q) < MAX_OUTSTANDING) &&
                 ((32'(fifo_cnt_q) + 32'(out_q)) < FIFO_DEPTH);
    // A redirect in IDLE only moves the PC; elsewhere it empties the buffer
    flush      = redirect_i && (state_q != S_IDLE);
    push       = gnt_ok && (discard_q == '0) && !redirect_i;
    drop       = gnt_ok && (discard_q != '0) && !redirect_i;
    pop        = !fifo_empty && instr_ready_i && !flush;
  end

  assign instr_req_o   = issue;
  assign instr_addr_o  = fetch_pc_q;
  assign instr_valid_o = !fifo_empty;
  assign instr_o       = fifo_empty ? NO_OP : fifo_data_mem[fifo_rd_q];
  assign instr_pc_o    = fifo_empty ? 32'h0 : fifo_pc_mem[fifo_rd_q];
  assign busy_o        = (state_q != S_IDLE) || (out_q != '0);
  assign err_o         = err_q;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enable_i) state_d = S_RUN;
      S_RUN:   if (!enable_i) state_d = S_STOP;
      S_STOP: begin
        if (enable_i)           state_d = S_RUN;
        else if (out_q == '0)   state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, PC, outstanding/discard counters and sticky error
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= BOOT_ADDR;
      out_q      <= '0;
      discard_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (redirect_i)  fetch_pc_q <= {redirect_addr_i[31:2], 2'b00};
      else if (issue)  fetch_pc_q <= fetch_pc_q + 32'd4;
      case ({issue, gnt_ok})
        2'b10:   out_q <= out_q + OC_W'(1);
        2'b01:   out_q <= out_q - OC_W'(1);
        default: out_q <= out_q;
      endcase
      // Everything still in flight after this cycle belongs to the old stream
      if (redirect_i)  discard_q <= out_q - OC_W'(gnt_ok);
      else if (drop)   discard_q <= discard_q - OC_W'(1);
      if (gnt_bad)     err_q <= 1'b1;
    end
  end

  // In-order PC tag queue pointers; occupancy always equals out_q
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pcq_wr_q <= '0;
      pcq_rd_q <= '0;
    end else begin
      if (issue)
        pcq_wr_q <= (pcq_wr_q == QA_W'(MAX_OUTSTANDING - 1)) ? '0 : pcq_wr_q + QA_W'(1);
      if (gnt_ok)
        pcq_rd_q <= (pcq_rd_q == QA_W'(MAX_OUTSTANDING - 1)) ? '0 : pcq_rd_q + QA_W'(1);
    end
  end

  // PC tag queue storage
  always_ff @(posedge clk_i) begin
    if (issue) pcq_mem[pcq_wr_q] <= fetch_pc_q;
  end

  // Instruction FIFO pointers and occupancy
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
      fifo_cnt_q <= '0;
    end else if (flush) begin
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) fifo_wr_q <= fifo_wr_q + FA_W'(1);
      if (pop)  fifo_rd_q <= fifo_rd_q + FA_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + FC_W'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - FC_W'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // Instruction FIFO storage, tagged with the PC popped from the tag queue
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_pc_mem[fifo_wr_q]   <= pcq_mem[pcq_rd_q];
      fifo_data_mem[fifo_wr_q] <= instr_rdata_i;
    end
  end

endmodule

// File: tb/tb_instr_fetch_master.sv
// Directed bench for instr_fetch_master with a fixed-latency model responder
// (data = 0xA000_0000 | addr) and an injectable stray grant.
module tb_instr_fetch_master;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        enable_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_addr_i = 32'h0;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic [31:0] instr_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i = 1'b0;
  logic        busy_o;
  logic        err_o;

  logic        slow_resp = 1'b0;
  logic        inj_gnt = 1'b0;
  logic [31:0] inj_rdata = 32'h0;
  logic [2:0]  pv;
  logic [31:0] pa [3];
  logic        resp_gnt;
  logic [31:0] resp_addr;

  int errors = 0;
  int checks = 0;

  instr_fetch_master dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i),
    .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
    .instr_gnt_i(instr_gnt_i), .instr_rdata_i(instr_rdata_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .instr_ready_i(instr_ready_i), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Responder: answers every request after 1 or 3 cycles, in order
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pv <= '0;
    end else begin
      pv    <= {pv[1:0], instr_req_o};
      pa[0] <= instr_addr_o;
      pa[1] <= pa[0];
      pa[2] <= pa[1];
    end
  end
  assign resp_gnt      = slow_resp ? pv[2] : pv[0];
  assign resp_addr     = slow_resp ? pa[2] : pa[0];
  assign instr_gnt_i   = resp_gnt | inj_gnt;
  assign instr_rdata_i = resp_gnt ? (32'hA000_0000 | resp_addr) : inj_rdata;

  task automatic apply_reset;
    rst_i = 1'b1; enable_i = 1'b0; redirect_i = 1'b0; instr_ready_i = 1'b0;
    inj_gnt = 1'b0; slow_resp = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset();
    checks++; if (instr_req_o !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", instr_req_o); end
    checks++; if (instr_addr_o !== 32'h80) begin errors++; $display("FAIL rst_addr: got %h want 00000080", instr_addr_o); end
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", instr_valid_o); end
    checks++; if (instr_o !== 32'h13) begin errors++; $display("FAIL rst_instr: got %h want 00000013", instr_o); end
    checks++; if (instr_pc_o !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", instr_pc_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err_o); end
  endtask

  task automatic test_stream;
    logic [31:0] exp_pc;
    apply_reset();
    instr_ready_i = 1'b1; enable_i = 1'b1;
    @(negedge clk_i);
    checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h80) begin
      errors++; $display("FAIL first_req: req=%b addr=%h want req=1 addr=00000080", instr_req_o, instr_addr_o); end
    @(negedge clk_i);
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL early_valid: got %b want 0", instr_valid_o); end
    @(negedge clk_i);
    checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h80 || instr_o !== 32'hA000_0080) begin
      errors++; $display("FAIL first_valid: v=%b pc=%h instr=%h want 1/00000080/a0000080", instr_valid_o, instr_pc_o, instr_o); end
    exp_pc = 32'h84;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== exp_pc || instr_o !== (32'hA000_0000 | exp_pc)) begin
        errors++; $display("FAIL stream: v=%b pc=%h instr=%h want pc=%h", instr_valid_o, instr_pc_o, instr_o, exp_pc); end
      exp_pc += 32'd4;
    end
  endtask

  task automatic test_backpressure;
    int nreq;
    logic [31:0] exp_pc;
    logic got;
    apply_reset();
    instr_ready_i = 1'b0; enable_i = 1'b1;
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (instr_req_o) begin
        checks++; if (instr_addr_o !== 32'h80 + 32'(4 * nreq)) begin
          errors++; $display("FAIL bp_addr: got %h want %h", instr_addr_o, 32'h80 + 32'(4 * nreq)); end
        nreq++;
      end
    end
    checks++; if (nreq !== 4) begin errors++; $display("FAIL bp_count: got %0d want 4", nreq); end
    checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h80) begin
      errors++; $display("FAIL bp_head: v=%b pc=%h want 1/00000080", instr_valid_o, instr_pc_o); end
    instr_ready_i = 1'b1;
    exp_pc = 32'h84; got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (instr_req_o && !got) begin
        got = 1'b1;
        checks++; if (instr_addr_o !== 32'h90) begin errors++; $display("FAIL bp_resume: got %h want 00000090", instr_addr_o); end
      end
      checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== exp_pc || instr_o !== (32'hA000_0000 | exp_pc)) begin
        errors++; $display("FAIL bp_drain: v=%b pc=%h want pc=%h", instr_valid_o, instr_pc_o, exp_pc); end
      exp_pc += 32'd4;
    end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL bp_no_resume: got %b want 1", got); end
  endtask

  task automatic test_redirect;
    logic got_req, got_val;
    apply_reset();
    slow_resp = 1'b1; instr_ready_i = 1'b1; enable_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checks++; if (instr_req_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL rd_sat: req=%b busy=%b want 0/1", instr_req_o, busy_o); end
    redirect_i = 1'b1; redirect_addr_i = 32'h0000_0203;
    @(negedge clk_i);
    redirect_i = 1'b0;
    checks++; if (instr_valid_o !== 1'b0 || instr_addr_o !== 32'h200) begin
      errors++; $display("FAIL rd_after: v=%b addr=%h want 0/00000200", instr_valid_o, instr_addr_o); end
    got_req = 1'b0; got_val = 1'b0;
    for (int i = 0; i < 20 && !got_val; i++) begin
      @(negedge clk_i);
      if (instr_req_o && !got_req) begin
        got_req = 1'b1;
        checks++; if (instr_addr_o !== 32'h200) begin errors++; $display("FAIL rd_req: got %h want 00000200", instr_addr_o); end
      end
      if (instr_valid_o) begin
        got_val = 1'b1;
        checks++; if (instr_pc_o !== 32'h200 || instr_o !== 32'hA000_0200) begin
          errors++; $display("FAIL rd_first: pc=%h instr=%h want 00000200/a0000200", instr_pc_o, instr_o); end
      end
    end
    checks++; if (got_val !== 1'b1) begin errors++; $display("FAIL rd_timeout: got %b want 1", got_val); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rd_err: got %b want 0", err_o); end
  endtask

  task automatic test_redirect_flush;
    logic got_val;
    apply_reset();
    instr_ready_i = 1'b0; enable_i = 1'b1;
    repeat (8) @(negedge clk_i);
    checks++; if (instr_valid_o !== 1'b1 || instr_req_o !== 1'b0) begin
      errors++; $display("FAIL rf_full: v=%b req=%b want 1/0", instr_valid_o, instr_req_o); end
    redirect_i = 1'b1; redirect_addr_i = 32'h0000_0301; instr_ready_i = 1'b1;
    @(negedge clk_i);
    redirect_i = 1'b0;
    checks++; if (instr_valid_o !== 1'b0 || instr_o !== 32'h13 || instr_pc_o !== 32'h0) begin
      errors++; $display("FAIL rf_flush: v=%b instr=%h pc=%h want 0/00000013/0", instr_valid_o, instr_o, instr_pc_o); end
    got_val = 1'b0;
    for (int i = 0; i < 10 && !got_val; i++) begin
      @(negedge clk_i);
      if (instr_valid_o) begin
        got_val = 1'b1;
        checks++; if (instr_pc_o !== 32'h300 || instr_o !== 32'hA000_0300) begin
          errors++; $display("FAIL rf_first: pc=%h instr=%h want 00000300/a0000300", instr_pc_o, instr_o); end
      end
    end
    checks++; if (got_val !== 1'b1) begin errors++; $display("FAIL rf_timeout: got %b want 1", got_val); end
  endtask

  task automatic test_slow_disable;
    int issued, popped, tb_out, max_out;
    logic [31:0] exp_pc;
    logic done;
    apply_reset();
    slow_resp = 1'b1; instr_ready_i = 1'b1; enable_i = 1'b1;
    issued = 0; popped = 0; tb_out = 0; max_out = 0; exp_pc = 32'h80;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk_i);
      if (instr_req_o) begin issued++; tb_out++; end
      if (instr_gnt_i) tb_out--;
      if (tb_out > max_out) max_out = tb_out;
      if (instr_valid_o) begin
        checks++; if (instr_pc_o !== exp_pc || instr_o !== (32'hA000_0000 | exp_pc)) begin
          errors++; $display("FAIL sl_order: pc=%h instr=%h want pc=%h", instr_pc_o, instr_o, exp_pc); end
        exp_pc += 32'd4; popped++;
      end
    end
    enable_i = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk_i);
      if (i == 0) begin
        checks++; if (instr_req_o !== 1'b0) begin errors++; $display("FAIL sl_stop_req: got %b want 0", instr_req_o); end
      end
      if (instr_req_o) issued++;
      if (instr_valid_o) begin
        checks++; if (instr_pc_o !== exp_pc) begin
          errors++; $display("FAIL sl_drain: pc=%h want %h", instr_pc_o, exp_pc); end
        exp_pc += 32'd4; popped++;
      end
      if (!busy_o && !instr_valid_o) done = 1'b1;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL sl_idle_timeout: got %b want 1", done); end
    checks++; if (popped !== issued) begin errors++; $display("FAIL sl_loss: popped %0d want %0d", popped, issued); end
    checks++; if (max_out !== 2) begin errors++; $display("FAIL sl_max_out: got %0d want 2", max_out); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL sl_err: got %b want 0", err_o); end
  endtask

  task automatic test_err;
    apply_reset();
    @(negedge clk_i);
    inj_gnt = 1'b1; inj_rdata = 32'hDEAD_BEEF;
    @(negedge clk_i);
    inj_gnt = 1'b0;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", err_o); end
    checks++; if (instr_valid_o !== 1'b0 || instr_o !== 32'h13 || instr_pc_o !== 32'h0) begin
      errors++; $display("FAIL err_fifo: v=%b instr=%h pc=%h want 0/00000013/0", instr_valid_o, instr_o, instr_pc_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL err_busy: got %b want 0", busy_o); end
    repeat (4) @(negedge clk_i);
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err_o); end
    apply_reset();
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", err_o); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_flush();
    test_slow_disable();
    test_err();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
